collision_detector: RTL

COLLISION_DETECTOR -- requirements
Module: collision_detector

---
 rtl/collision_detector.sv | 136 +++++++++++++
 1 files changed

// File: rtl/collision_detector.sv
//------------------------------------------------------------------------------
// Module   : collision_detector
// Brief    : Bullet/player overlap detector with per-frame hit evaluation,
//            hit-point tracking, post-hit invulnerability cooldown and death.
//            Optional macro HIT_FLASH_EN enables the cooldown blink output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module collision_detector #(
  parameter int HP_INIT         = 5,
  parameter int COOLDOWN_FRAMES = 60
) (
  input  logic       Pclk,
  input  logic       rst_n,
  input  logic [9:0] xx,
  input  logic [9:0] yy,
  input  logic       aactive,
  input  logic       BulletSpriteOn,
  input  logic       PlayerSpriteOn,
  output logic       isCollisionB1,
  output logic [3:0] HP,
  output logic       PlayerDead,
  output logic       HitFlash
);

  localparam logic [1:0] S_ALIVE    = 2'd0;
  localparam logic [1:0] S_COOLDOWN = 2'd1;
  localparam logic [1:0] S_DEAD     = 2'd2;

  localparam logic [9:0] c_X_LAST  = 10'd639;
  localparam logic [9:0] c_Y_LAST  = 10'd479;
  localparam logic [3:0] c_HP_INIT = 4'(HP_INIT);
  localparam logic [7:0] c_COOL    = 8'(COOLDOWN_FRAMES);

  logic [1:0] r_state, w_state_nxt;
  logic [3:0] r_hp, w_hp_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_pend;
  logic       r_prev_end;
  logic       r_coll, w_coll_nxt;
  logic       r_dead, w_dead_nxt;

  // Last active pixel of the frame; the tick fires only on its rising edge so
  // a position held for several clocks still ends the frame exactly once.
  logic w_at_end, w_tick, w_ovl, w_hit;
  assign w_at_end = (xx == c_X_LAST) && (yy == c_Y_LAST);
  assign w_tick   = w_at_end && !r_prev_end;
  assign w_ovl    = aactive && BulletSpriteOn && PlayerSpriteOn;
  // An overlap on the tick cycle itself still belongs to the ending frame.
  assign w_hit    = r_pend || w_ovl;

  // Frame-edge detector and sticky overlap flag, cleared at every frame tick
  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_end <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      r_prev_end <= w_at_end;
      r_pend     <= w_tick ? 1'b0 : (r_pend || w_ovl);
    end
  end

  // State register
  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) r_state <= S_ALIVE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: transitions happen only on a frame tick
  always_comb begin
    w_state_nxt = r_state;
    if (w_tick) begin
      case (r_state)
        S_ALIVE:    if (w_hit) w_state_nxt = (r_hp > 4'd1) ? S_COOLDOWN : S_DEAD;
        S_COOLDOWN: if (r_cnt <= 8'd1) w_state_nxt = S_ALIVE;
        S_DEAD:     w_state_nxt = S_DEAD;
        default:    w_state_nxt = S_ALIVE;
      endcase
    end
  end

  // Output/datapath logic: next HP, cooldown counter and status flags
  always_comb begin
    w_hp_nxt  = r_hp;
    w_cnt_nxt = r_cnt;
    if (w_tick) begin
      if (r_state == S_ALIVE && w_hit) begin
        if (r_hp > 4'd1) begin
          w_hp_nxt  = r_hp - 4'd1;
          w_cnt_nxt = c_COOL;
        end else begin
          w_hp_nxt  = 4'd0;
        end
      end else if (r_state == S_COOLDOWN && r_cnt != 8'd0) begin
        w_cnt_nxt = r_cnt - 8'd1;
      end
    end
    w_coll_nxt = (w_state_nxt != S_ALIVE);
    w_dead_nxt = (w_state_nxt == S_DEAD);
  end

  // Registered outputs and cooldown counter
  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hp   <= c_HP_INIT;
      r_cnt  <= 8'd0;
      r_coll <= 1'b0;
      r_dead <= 1'b0;
    end else begin
      r_hp   <= w_hp_nxt;
      r_cnt  <= w_cnt_nxt;
      r_coll <= w_coll_nxt;
      r_dead <= w_dead_nxt;
    end
  end

  assign HP            = r_hp;
  assign isCollisionB1 = r_coll;
  assign PlayerDead    = r_dead;

`ifdef HIT_FLASH_EN
  logic r_flash;
  // Blink follows bit 2 of the remaining cooldown frames, giving a 4-frame toggle
  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) r_flash <= 1'b0;
    else        r_flash <= (w_state_nxt == S_COOLDOWN) && w_cnt_nxt[2];
  end
  assign HitFlash = r_flash;
`else
  assign HitFlash = 1'b0;
`endif

endmodule

`default_nettype wire
